dii_packet_fifo: RTL

DII_PACKET_FIFO -- requirements
Module: dii_packet_fifo

---
 rtl/dii_packet_fifo_if.sv | 24 ++
 rtl/dii_packet_fifo.sv | 116 +++++++++++
 2 files changed

// File: rtl/dii_packet_fifo_if.sv
// Flit handshake bundle for dii_packet_fifo: write side (in_*) and read side (out_*).
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface dii_packet_fifo_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/dii_packet_fifo.sv
// Circular flit FIFO with optional store-and-forward packet mode, packet counting,
// head-packet size scan and sticky overflow release for packets longer than DEPTH.
module dii_packet_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int FULLPACKET = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  dii_packet_fifo_if.slave       fifo_if,
  output logic [$clog2(DEPTH):0] fill_level_o,
  output logic [$clog2(DEPTH):0] packet_count_o,
  output logic [$clog2(DEPTH):0] packet_size_o,
  output logic                   overflow_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic          PKT_MODE = (FULLPACKET != 0);

  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0] last_mem_q;
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    fill_q, pcnt_q;
  logic             release_q, overflow_q;

  logic             in_ready_s, out_valid_s, out_last_s;
  logic             in_fire_s, out_fire_s, in_pkt_s, out_pkt_s;
  logic             pkt_ok_s, set_release_s;
  logic [CW-1:0]    size_s;
  logic [AW-1:0]    scan_idx_s;
  logic             scan_found_s, scan_hit_s;

  // In packet mode the head is only offered once a whole packet (or a forced release) is stored.
  assign pkt_ok_s      = PKT_MODE ? ((pcnt_q != '0) || release_q) : 1'b1;
  assign in_ready_s    = !rst && !flush_i && (fill_q != FULL_LVL);
  assign out_valid_s   = !rst && !flush_i && (fill_q != '0) && pkt_ok_s;
  assign out_last_s    = last_mem_q[rp_q];
  assign in_fire_s     = fifo_if.in_valid && in_ready_s;
  assign out_fire_s    = out_valid_s && fifo_if.out_ready;
  assign in_pkt_s      = in_fire_s && fifo_if.in_last;
  assign out_pkt_s     = out_fire_s && out_last_s;
  assign set_release_s = PKT_MODE && (fill_q == FULL_LVL) && (pcnt_q == '0) && !release_q;

  assign fifo_if.in_ready  = in_ready_s;
  assign fifo_if.out_valid = out_valid_s;
  assign fifo_if.out_data  = data_mem_q[rp_q];
  assign fifo_if.out_last  = out_last_s;

  assign fill_level_o   = fill_q;
  assign packet_count_o = pcnt_q;
  assign packet_size_o  = size_s;
  assign overflow_err_o = overflow_q;

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (in_fire_s) begin
      data_mem_q[wp_q] <= fifo_if.in_data;
      last_mem_q[wp_q] <= fifo_if.in_last;
    end
  end

  // Pointers, occupancy counters, release and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q      <= '0;
      rp_q      <= '0;
      fill_q    <= '0;
      pcnt_q    <= '0;
      release_q <= 1'b0;
      if (rst) begin
        overflow_q <= 1'b0;
      end
    end else begin
      if (in_fire_s) begin
        wp_q <= wp_q + PTR_ONE;
      end
      if (out_fire_s) begin
        rp_q <= rp_q + PTR_ONE;
      end
      case ({in_fire_s, out_fire_s})
        2'b10:   fill_q <= fill_q + CNT_ONE;
        2'b01:   fill_q <= fill_q - CNT_ONE;
        default: fill_q <= fill_q;
      endcase
      case ({in_pkt_s, out_pkt_s})
        2'b10:   pcnt_q <= pcnt_q + CNT_ONE;
        2'b01:   pcnt_q <= pcnt_q - CNT_ONE;
        default: pcnt_q <= pcnt_q;
      endcase
      if (out_pkt_s) begin
        release_q <= 1'b0;
      end else if (set_release_s) begin
        release_q  <= 1'b1;
        overflow_q <= 1'b1;
      end
    end
  end

  // Head packet size: distance from rp to the first stored last flit, plus one.
  always_comb begin
    size_s       = '0;
    scan_found_s = 1'b0;
    scan_idx_s   = rp_q;
    scan_hit_s   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s   = rp_q + AW'(i);
      scan_hit_s   = PKT_MODE && !scan_found_s && (CW'(i) < fill_q) && last_mem_q[scan_idx_s];
      size_s       = scan_hit_s ? CW'(i + 1) : size_s;
      scan_found_s = scan_found_s || scan_hit_s;
    end
  end
endmodule
